// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one DRAM request port between the loader (0) and CPU (1), one access in flight, with watchdog abort
module dram_arbiter #(
  parameter int          LOADER_PRIO = 0,
  parameter int          TIMEOUT     = 1024,
  parameter logic [31:0] ABORT_DATA  = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [3:0]  r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic [3:0]  r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        m_req,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        err
);
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t        r_state;
  logic          r_last;
  logic          r_grant;
  logic [WW-1:0] r_wdog;
  logic          w_tie;
  logic          w_pick;
  logic          w_abort;
  always_comb begin
    w_tie   = r0_req && r1_req;
    w_pick  = r1_req && (!r0_req || (LOADER_PRIO == 0 && !r_last));
    w_abort = (TIMEOUT != 0) && (r_wdog == WW'(TIMEOUT - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_wdog   <= '0;
      m_req    <= 1'b0;
      m_we     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (r0_req || r1_req) begin
          r_state <= ISSUE;
          r_grant <= w_pick;
          if (w_tie) r_last <= w_pick;
          r_wdog  <= '0;
          m_req   <= 1'b1;
          busy    <= 1'b1;
          m_we    <= w_pick ? r1_we : r0_we;
          m_addr  <= w_pick ? r1_addr : r0_addr;
          m_wdata <= w_pick ? r1_wdata : r0_wdata;
        end
        ISSUE: if (m_ack || w_abort) begin
          r_state <= RESP;
          m_req   <= 1'b0;
          if (r_grant) r1_rdata <= m_ack ? m_rdata : ABORT_DATA;
          else r0_rdata <= m_ack ? m_rdata : ABORT_DATA;
          r0_ack  <= !r_grant;
          r1_ack  <= r_grant;
          if (!m_ack) err <= 1'b1;
        end else begin
          r_wdog <= r_wdog + WW'(1);
        end
        RESP: begin
          r_state <= IDLE;
          r0_ack  <= 1'b0;
          r1_ack  <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
